// File: rtl/evt_pkg.sv
// Shared types and width helpers for the event-strobe burst generator and its counter.
package evt_pkg;

  typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} evt_gen_state_t;

  localparam int DEF_MAX_COUNT  = 255;
  localparam int DEF_MAX_PERIOD = 65535;

  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  function automatic int period_width(input int max_period);
    return $clog2(max_period + 1);
  endfunction

  // A single-event counter still needs one bit of index.
  function automatic int idx_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/evt_counter.sv
// Modulo-MAX_COUNT event counter: advances once per cycle that evt_in is high.
module evt_counter
  import evt_pkg::*;
#(
  parameter int  MAX_COUNT = DEF_MAX_COUNT,
  localparam int IW        = idx_width(MAX_COUNT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          evt_in,
  output logic [IW-1:0] count_out
);

  localparam logic [IW-1:0] LAST = IW'(MAX_COUNT - 1);

  logic [IW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (evt_in) begin
      count_d = (count_q == LAST) ? '0 : count_q + IW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/evt_burst_gen.sv
// Event-strobe transmitter: accepts {count, period} and emits count one-cycle
// evt_out pulses spaced period cycles apart, tagged 0..count-1 on evt_idx_out.
module evt_burst_gen
  import evt_pkg::*;
#(
  parameter int  MAX_COUNT  = DEF_MAX_COUNT,
  parameter int  MAX_PERIOD = DEF_MAX_PERIOD,
  localparam int CW         = count_width(MAX_COUNT),
  localparam int PW         = period_width(MAX_PERIOD),
  localparam int IW         = idx_width(MAX_COUNT)
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           cmd_valid_in,
  output logic           cmd_ready_out,
  input  logic [CW-1:0]  cmd_count_in,
  input  logic [PW-1:0]  cmd_period_in,
  input  logic           abort_in,
  output logic           evt_out,
  output logic [IW-1:0]  evt_idx_out,
  output logic           busy_out,
  output logic           done_out,
  output logic           aborted_out,
  output evt_gen_state_t state_dbg_out
);

  // Handshake: a command transfers on any rising clk_in edge where
  // cmd_valid_in && cmd_ready_out; the master keeps valid and payload stable
  // until that edge, and ready is only offered in IDLE outside reset.

  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_COUNT);

  evt_gen_state_t state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  period_q, period_d;
  logic [PW-1:0]  gap_q, gap_d;
  logic           aborted_q, aborted_d;

  logic           accept;
  logic [CW-1:0]  count_clamped;
  logic           last_pulse;
  logic           idx_rst;
  logic           idx_evt;
  logic [IW-1:0]  idx;

  assign cmd_ready_out = (state_q == IDLE) && !rst_in;
  assign accept        = cmd_valid_in && cmd_ready_out;
  assign count_clamped = (cmd_count_in > COUNT_MAX) ? COUNT_MAX : cmd_count_in;
  assign last_pulse    = (CW'(idx) == count_q - CW'(1));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    gap_d     = gap_q;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          count_d  = count_clamped;
          period_d = (cmd_period_in == '0) ? PW'(1) : cmd_period_in;
          state_d  = (count_clamped == '0) ? DONE : EMIT;
        end
      end
      EMIT: begin
        // Abort wins over the last-pulse exit so aborted_out reports it.
        if (abort_in) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (last_pulse) begin
          state_d = DONE;
        end else if (period_q == PW'(1)) begin
          state_d = EMIT;
        end else begin
          gap_d   = period_q - PW'(1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (abort_in) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (gap_q == PW'(1)) begin
          state_d = EMIT;
        end else begin
          gap_d = gap_q - PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      gap_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      gap_q     <= gap_d;
      aborted_q <= aborted_d;
    end
  end

  // The index advances only after a pulse that is followed by another one.
  assign idx_rst = rst_in || accept;
  assign idx_evt = (state_q == EMIT) && ((state_d == EMIT) || (state_d == GAP));

  evt_counter #(
    .MAX_COUNT (MAX_COUNT)
  ) u_idx_cnt (
    .clk_in    (clk_in),
    .rst_in    (idx_rst),
    .evt_in    (idx_evt),
    .count_out (idx)
  );

  assign evt_out       = (state_q == EMIT);
  assign evt_idx_out   = idx;
  assign busy_out      = (state_q != IDLE);
  assign done_out      = (state_q == DONE);
  assign aborted_out   = aborted_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Bench for evt_burst_gen: directed table, reset corner case and random commands
// checked cycle by cycle against an arithmetic pulse-schedule model.
module tb_evt_burst_gen;
  import evt_pkg::*;

  localparam int MC = 8;
  localparam int MP = 16;
  localparam int CW = 4;
  localparam int PW = 5;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [CW-1:0]  cmd_count;
  logic [PW-1:0]  cmd_period;
  logic           abort;
  logic           evt;
  logic [IW-1:0]  evt_idx;
  logic           busy;
  logic           done;
  logic           aborted;
  evt_gen_state_t state_dbg;
  logic [IW-1:0]  ds_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  evt_burst_gen #(.MAX_COUNT(MC), .MAX_PERIOD(MP)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .cmd_valid_in  (cmd_valid),
    .cmd_ready_out (cmd_ready),
    .cmd_count_in  (cmd_count),
    .cmd_period_in (cmd_period),
    .abort_in      (abort),
    .evt_out       (evt),
    .evt_idx_out   (evt_idx),
    .busy_out      (busy),
    .done_out      (done),
    .aborted_out   (aborted),
    .state_dbg_out (state_dbg)
  );

  // Downstream consumer of the strobe.
  evt_counter #(.MAX_COUNT(MC)) u_ds_cnt (
    .clk_in    (clk),
    .rst_in    (rst),
    .evt_in    (evt),
    .count_out (ds_cnt)
  );

  typedef struct {
    int cnt;
    int per;
    int ab;
    int exp_pulses;
    int exp_done;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issues one command at cycle 0 and checks every cycle up to the return of ready.
  // ab = cycle in which abort_in is held high (-1 = never).
  task automatic run_cmd(input int cnt, input int per, input int ab,
                         output int pulses, output int done_at);
    int n, p, last, d, lim, w, ds_base;
    bit abt, exp_evt;
    pulses  = 0;
    done_at = -1;
    n = (cnt > MC) ? MC : cnt;
    p = (per == 0) ? 1 : per;
    abt = 1'b0;
    if (n == 0) begin
      d   = 1;
      lim = 0;
    end else begin
      last = 1 + (n - 1) * p;
      if (ab >= 1 && ab <= last) begin
        d   = ab + 1;
        lim = ab;
        abt = 1'b1;
      end else begin
        d   = last + 1;
        lim = last;
      end
    end
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      check("ready_wait", 0, 1);
      return;
    end
    ds_base    = int'(ds_cnt);
    cmd_valid  = 1'b1;
    cmd_count  = CW'(cnt);
    cmd_period = PW'(per);
    abort      = (ab == 0);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_count  = CW'($urandom);
    cmd_period = PW'($urandom);
    for (int t = 1; t <= d + 1; t++) begin
      abort = (t == ab);
      @(negedge clk);
      exp_evt = (t <= lim) && (((t - 1) % p) == 0);
      check("evt", int'(evt), int'(exp_evt));
      if (exp_evt) begin
        check("evt_idx", int'(evt_idx), (t - 1) / p);
        check("ds_cnt", int'(ds_cnt), (ds_base + (t - 1) / p) % MC);
      end
      check("busy", int'(busy), int'(t <= d));
      check("done", int'(done), int'(t == d));
      if (t == d) check("aborted", int'(aborted), int'(abt));
      check("ready", int'(cmd_ready), int'(t == d + 1));
      if (evt) pulses++;
      if (done && done_at < 0) done_at = t;
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    int pulses, done_at, cnt, per, ab;
    vecs.push_back('{3, 4, -1, 3, 10});
    vecs.push_back('{4, 0, -1, 4, 5});
    vecs.push_back('{4, 1, -1, 4, 5});
    vecs.push_back('{0, 5, -1, 0, 1});
    vecs.push_back('{3, 4, 6, 2, 7});
    vecs.push_back('{8, 2, -1, 8, 16});
    vecs.push_back('{12, 1, -1, 8, 9});
    vecs.push_back('{3, 2, 5, 3, 6});
    vecs.push_back('{5, 3, 1, 1, 2});
    vecs.push_back('{2, 3, 0, 2, 5});
    vecs.push_back('{0, 1, 1, 0, 1});
    vecs.push_back('{1, 16, -1, 1, 2});

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_count  = '0;
    cmd_period = '0;
    abort      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_evt", int'(evt), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_idx", int'(evt_idx), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(cmd_ready), 1);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].cnt, vecs[i].per, vecs[i].ab, pulses, done_at);
      check("vec_pulses", pulses, vecs[i].exp_pulses);
      check("vec_done_cycle", done_at, vecs[i].exp_done);
    end

    // Reset mid-burst with a command already waiting on the handshake.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_count  = 4'd3;
    cmd_period = 5'd4;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("r_c1_evt", int'(evt), 1);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_count  = 4'd2;
    cmd_period = 5'd1;
    @(negedge clk);
    check("r_c2_busy", int'(busy), 1);
    check("r_c2_ready", int'(cmd_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("r_c3_ready", int'(cmd_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("r_c4_busy", int'(busy), 0);
    check("r_c4_evt", int'(evt), 0);
    check("r_c4_done", int'(done), 0);
    check("r_c4_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("r_c5_evt", int'(evt), 1);
    check("r_c5_idx", int'(evt_idx), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("r_c6_evt", int'(evt), 1);
    check("r_c6_idx", int'(evt_idx), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("r_c7_done", int'(done), 1);
    check("r_c7_aborted", int'(aborted), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("r_c8_ready", int'(cmd_ready), 1);

    for (int k = 0; k < 40; k++) begin
      cnt = $urandom_range(0, 12);
      per = $urandom_range(0, 6);
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
      run_cmd(cnt, per, ab, pulses, done_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
